// File: rtl/data_mem_responder.sv
// data_mem_responder
//   Shared 16-bit data memory for the two matrix-multiplication cores.
//   The host fills the memory over a valid/ready load stream. It then pulses
//   host_start and the cores run against the memory through their own ports.
//   When core_done rises, the result region is streamed back to the host.
//
// Ports
//   clock, RST                  rising-edge clock, async active-high reset
//   write_en1/addr_data_1/      core1 port; dataout1 is registered and reads 0
//   datain1/dataout1              outside RUN
//   write_en2/addr_data_2/      core2 port; same behaviour as core1
//   datain2/dataout2
//   host_valid/host_data/       load stream (LOAD state only)
//   host_ready
//   host_start                  pulse: LOAD -> RUN
//   core_run                    high while the cores may execute
//   core_done                   level: both cores finished (RUN -> DUMP)
//   dump_valid/dump_data/       result stream of DUMP_LEN words starting at
//   dump_last/dump_ready          DUMP_BASE
//   collision                   sticky same-address dual-write flag
//
// Build option
//   COLLISION_DETECT_EN  when defined, collision latches same-address dual
//                        writes seen during RUN. When undefined, collision is 0.
//                        Core1 keeps write priority in both builds.

module data_mem_responder #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 8,
  parameter logic [ADDR_W-1:0] DUMP_BASE = 8'h80,
  parameter int                DUMP_LEN  = 16
) (
  input  logic              clock,
  input  logic              RST,
  input  logic              write_en1,
  input  logic [ADDR_W-1:0] addr_data_1,
  input  logic [DATA_W-1:0] datain1,
  output logic [DATA_W-1:0] dataout1,
  input  logic              write_en2,
  input  logic [ADDR_W-1:0] addr_data_2,
  input  logic [DATA_W-1:0] datain2,
  output logic [DATA_W-1:0] dataout2,
  input  logic              host_valid,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  input  logic              host_start,
  output logic              core_run,
  input  logic              core_done,
  output logic              dump_valid,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_last,
  input  logic              dump_ready,
  output logic              collision
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DUMP_LEN - 1);

  // The dump is split into sub-states. SETUP is visited only on entry, so the
  // first word appears two cycles after core_done. Later words alternate
  // READ/HOLD, which gives the one-cycle valid gap after each handshake.
  typedef enum logic [2:0] {
    S_LOAD,
    S_RUN,
    S_DUMP_SETUP,
    S_DUMP_READ,
    S_DUMP_HOLD
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] load_ptr;
  logic [ADDR_W-1:0] dump_ptr;
  logic [CNT_W-1:0]  dump_cnt;
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic load_hs;
  logic same_addr_wr;
  logic run_next;

  assign load_hs      = (state == S_LOAD) && host_valid && host_ready;
  assign same_addr_wr = write_en1 && write_en2 && (addr_data_1 == addr_data_2);
  // The read ports return data only in cycles whose state is RUN.
  assign run_next     = ((state == S_LOAD) && host_start) ||
                        ((state == S_RUN) && !core_done);

  // Control FSM with registered handshake and dump outputs.
  always_ff @(posedge clock or posedge RST) begin
    if (RST) begin
      state      <= S_LOAD;
      load_ptr   <= '0;
      dump_ptr   <= '0;
      dump_cnt   <= '0;
      host_ready <= 1'b1;
      core_run   <= 1'b0;
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_last  <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (load_hs) load_ptr <= load_ptr + 1'b1;
          if (host_start) begin
            state      <= S_RUN;
            host_ready <= 1'b0;
            core_run   <= 1'b1;
          end
        end
        S_RUN: begin
          if (core_done) begin
            state    <= S_DUMP_SETUP;
            core_run <= 1'b0;
            dump_ptr <= DUMP_BASE;
            dump_cnt <= '0;
          end
        end
        S_DUMP_SETUP: state <= S_DUMP_READ;
        S_DUMP_READ: begin
          dump_data  <= mem[dump_ptr];
          dump_valid <= 1'b1;
          dump_last  <= (dump_cnt == LAST_IDX);
          state      <= S_DUMP_HOLD;
        end
        S_DUMP_HOLD: begin
          if (dump_ready) begin
            dump_valid <= 1'b0;
            dump_last  <= 1'b0;
            if (dump_last) begin
              state      <= S_LOAD;
              host_ready <= 1'b1;
              load_ptr   <= '0;
              dump_ptr   <= '0;
              dump_data  <= '0;
            end else begin
              dump_ptr <= dump_ptr + 1'b1;
              dump_cnt <= dump_cnt + 1'b1;
              state    <= S_DUMP_READ;
            end
          end
        end
        default: state <= S_LOAD;
      endcase
    end
  end

  // Registered core read ports. Both are read-first, because the write below
  // lands on the same edge.
  always_ff @(posedge clock or posedge RST) begin
    if (RST) begin
      dataout1 <= '0;
      dataout2 <= '0;
    end else if (run_next) begin
      dataout1 <= mem[addr_data_1];
      dataout2 <= mem[addr_data_2];
    end else begin
      dataout1 <= '0;
      dataout2 <= '0;
    end
  end

  // Memory array. It has no reset, so its contents survive RST. Core2 loses a
  // same-address write to core1.
  always_ff @(posedge clock) begin
    if (load_hs) begin
      mem[load_ptr] <= host_data;
    end else if (state == S_RUN) begin
      if (write_en2 && !same_addr_wr) mem[addr_data_2] <= datain2;
      if (write_en1) mem[addr_data_1] <= datain1;
    end
  end

`ifdef COLLISION_DETECT_EN
  // Sticky flag. It is cleared when a new run starts.
  always_ff @(posedge clock or posedge RST) begin
    if (RST) begin
      collision <= 1'b0;
    end else if ((state == S_LOAD) && host_start) begin
      collision <= 1'b0;
    end else if ((state == S_RUN) && same_addr_wr) begin
      collision <= 1'b1;
    end
  end
`else
  assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed self-checking bench for data_mem_responder.

module tb_data_mem_responder;

  logic        clock;
  logic        RST;
  logic        write_en1;
  logic [7:0]  addr_data_1;
  logic [15:0] datain1;
  logic [15:0] dataout1;
  logic        write_en2;
  logic [7:0]  addr_data_2;
  logic [15:0] datain2;
  logic [15:0] dataout2;
  logic        host_valid;
  logic [15:0] host_data;
  logic        host_ready;
  logic        host_start;
  logic        core_run;
  logic        core_done;
  logic        dump_valid;
  logic [15:0] dump_data;
  logic        dump_last;
  logic        dump_ready;
  logic        collision;

  int checks = 0;
  int passed = 0;

`ifdef COLLISION_DETECT_EN
  localparam logic EXP_COLL = 1'b1;
`else
  localparam logic EXP_COLL = 1'b0;
`endif

  data_mem_responder dut (
    .clock(clock), .RST(RST),
    .write_en1(write_en1), .addr_data_1(addr_data_1), .datain1(datain1), .dataout1(dataout1),
    .write_en2(write_en2), .addr_data_2(addr_data_2), .datain2(datain2), .dataout2(dataout2),
    .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
    .host_start(host_start), .core_run(core_run), .core_done(core_done),
    .dump_valid(dump_valid), .dump_data(dump_data), .dump_last(dump_last),
    .dump_ready(dump_ready), .collision(collision)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    #3;
    checks++; if (host_ready !== 1'b1) $display("[TB] FAIL reset_host_ready: got %b expected 1", host_ready); else passed++;
    checks++; if (core_run !== 1'b0) $display("[TB] FAIL reset_core_run: got %b expected 0", core_run); else passed++;
    checks++; if (dump_valid !== 1'b0) $display("[TB] FAIL reset_dump_valid: got %b expected 0", dump_valid); else passed++;
    checks++; if (dump_last !== 1'b0) $display("[TB] FAIL reset_dump_last: got %b expected 0", dump_last); else passed++;
    checks++; if (dump_data !== 16'h0) $display("[TB] FAIL reset_dump_data: got %h expected 0000", dump_data); else passed++;
    checks++; if (dataout1 !== 16'h0 || dataout2 !== 16'h0) $display("[TB] FAIL reset_dataout: got %h/%h expected 0000/0000", dataout1, dataout2); else passed++;
    checks++; if (collision !== 1'b0) $display("[TB] FAIL reset_collision: got %b expected 0", collision); else passed++;
    tick();
    tick();
    RST = 1'b0;
    tick();
  endtask

  task automatic test_load_read();
    host_valid = 1'b1; host_data = 16'h0011; tick();
    host_data = 16'h0022; tick();
    host_data = 16'h0033; host_start = 1'b1; tick();
    host_valid = 1'b0; host_start = 1'b0;
    checks++; if (core_run !== 1'b1) $display("[TB] FAIL run_core_run: got %b expected 1", core_run); else passed++;
    checks++; if (host_ready !== 1'b0) $display("[TB] FAIL run_host_ready: got %b expected 0", host_ready); else passed++;
    addr_data_1 = 8'd2; addr_data_2 = 8'd0; tick();
    checks++; if (dataout1 !== 16'h0033) $display("[TB] FAIL load_read1: got %h expected 0033", dataout1); else passed++;
    checks++; if (dataout2 !== 16'h0011) $display("[TB] FAIL load_read2: got %h expected 0011", dataout2); else passed++;
  endtask

  task automatic test_collision();
    write_en1 = 1'b1; addr_data_1 = 8'd5; datain1 = 16'hAAAA;
    write_en2 = 1'b1; addr_data_2 = 8'd5; datain2 = 16'hBBBB;
    tick();
    write_en1 = 1'b0; write_en2 = 1'b0;
    tick();
    checks++; if (dataout2 !== 16'hAAAA) $display("[TB] FAIL collision_priority: got %h expected aaaa", dataout2); else passed++;
    checks++; if (collision !== EXP_COLL) $display("[TB] FAIL collision_flag: got %b expected %b", collision, EXP_COLL); else passed++;
  endtask

  task automatic test_read_during_write();
    write_en1 = 1'b1; addr_data_1 = 8'd9; datain1 = 16'h5555; tick();
    write_en1 = 1'b0;
    write_en2 = 1'b1; addr_data_2 = 8'd9; datain2 = 16'h1234; tick();
    write_en2 = 1'b0;
    checks++; if (dataout1 !== 16'h5555) $display("[TB] FAIL rdw_old: got %h expected 5555", dataout1); else passed++;
    tick();
    checks++; if (dataout1 !== 16'h1234) $display("[TB] FAIL rdw_new: got %h expected 1234", dataout1); else passed++;
    write_en1 = 1'b1; addr_data_1 = 8'd20; datain1 = 16'h0A0A;
    write_en2 = 1'b1; addr_data_2 = 8'd21; datain2 = 16'h0B0B;
    tick();
    write_en1 = 1'b0; write_en2 = 1'b0;
    addr_data_1 = 8'd21; addr_data_2 = 8'd20; tick();
    checks++; if (dataout1 !== 16'h0B0B || dataout2 !== 16'h0A0A) $display("[TB] FAIL dual_write: got %h/%h expected 0b0b/0a0a", dataout1, dataout2); else passed++;
  endtask

  task automatic test_dump();
    logic [15:0] exp_word;
    for (int i = 0; i < 16; i++) begin
      write_en1 = 1'b1; addr_data_1 = 8'h80 + 8'(i); datain1 = 16'(i); tick();
    end
    write_en1 = 1'b0;
    core_done = 1'b1; tick();
    core_done = 1'b0;
    checks++; if (core_run !== 1'b0 || dataout1 !== 16'h0) $display("[TB] FAIL dump_entry: got run=%b d1=%h expected run=0 d1=0000", core_run, dataout1); else passed++;
    checks++; if (dump_valid !== 1'b0) $display("[TB] FAIL dump_latency1: got %b expected 0", dump_valid); else passed++;
    tick();
    checks++; if (dump_valid !== 1'b0) $display("[TB] FAIL dump_latency2: got %b expected 0", dump_valid); else passed++;
    tick();
    tick();
    checks++; if (dump_valid !== 1'b1 || dump_data !== 16'h0) $display("[TB] FAIL dump_hold: got v=%b d=%h expected v=1 d=0000", dump_valid, dump_data); else passed++;
    for (int i = 0; i < 16; i++) begin
      dump_ready = 1'b1;
      exp_word = 16'(i);
      checks++; if (dump_valid !== 1'b1 || dump_data !== exp_word) $display("[TB] FAIL dump_word%0d: got v=%b d=%h expected v=1 d=%h", i, dump_valid, dump_data, exp_word); else passed++;
      checks++; if (dump_last !== (i == 15)) $display("[TB] FAIL dump_last%0d: got %b expected %b", i, dump_last, (i == 15)); else passed++;
      tick();
      if (i < 15) begin
        checks++; if (dump_valid !== 1'b0) $display("[TB] FAIL dump_gap%0d: got %b expected 0", i, dump_valid); else passed++;
        tick();
      end
    end
    dump_ready = 1'b0;
    checks++; if (host_ready !== 1'b1 || dump_valid !== 1'b0 || core_run !== 1'b0) $display("[TB] FAIL dump_to_load: got rdy=%b v=%b run=%b expected 1/0/0", host_ready, dump_valid, core_run); else passed++;
  endtask

  task automatic test_load_wrap();
    write_en1 = 1'b1; addr_data_1 = 8'h90; datain1 = 16'hDEAD; tick();
    write_en1 = 1'b0;
    checks++; if (dataout1 !== 16'h0) $display("[TB] FAIL load_dataout_zero: got %h expected 0000", dataout1); else passed++;
    host_valid = 1'b1;
    for (int i = 0; i < 256; i++) begin
      host_data = 16'h1000 + 16'(i); tick();
    end
    host_data = 16'hBEEF; tick();
    host_data = 16'hCAFE; host_start = 1'b1; tick();
    host_valid = 1'b0; host_start = 1'b0;
    checks++; if (collision !== 1'b0) $display("[TB] FAIL collision_clear: got %b expected 0", collision); else passed++;
    addr_data_1 = 8'd0; addr_data_2 = 8'd1; tick();
    checks++; if (dataout1 !== 16'hBEEF) $display("[TB] FAIL wrap_addr0: got %h expected beef", dataout1); else passed++;
    checks++; if (dataout2 !== 16'hCAFE) $display("[TB] FAIL wrap_ptr1: got %h expected cafe", dataout2); else passed++;
    addr_data_1 = 8'd2; addr_data_2 = 8'h90; tick();
    checks++; if (dataout1 !== 16'h1002) $display("[TB] FAIL wrap_addr2: got %h expected 1002", dataout1); else passed++;
    checks++; if (dataout2 !== 16'h1090) $display("[TB] FAIL load_write_ignored: got %h expected 1090", dataout2); else passed++;
  endtask

  task automatic test_reset_mid_dump();
    logic [15:0] exp_word;
    core_done = 1'b1; tick();
    core_done = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      dump_ready = 1'b1;
      exp_word = 16'h1080 + 16'(i);
      checks++; if (dump_data !== exp_word) $display("[TB] FAIL mid_word%0d: got %h expected %h", i, dump_data, exp_word); else passed++;
      tick();
      dump_ready = 1'b0;
      tick();
    end
    checks++; if (dump_valid !== 1'b1 || dump_data !== 16'h1083) $display("[TB] FAIL mid_word3: got v=%b d=%h expected v=1 d=1083", dump_valid, dump_data); else passed++;
    #2 RST = 1'b1;
    #1;
    checks++; if (dump_valid !== 1'b0 || host_ready !== 1'b1 || core_run !== 1'b0) $display("[TB] FAIL mid_reset: got v=%b rdy=%b run=%b expected 0/1/0", dump_valid, host_ready, core_run); else passed++;
    #2 RST = 1'b0;
    tick();
    host_start = 1'b1; tick();
    host_start = 1'b0;
    addr_data_1 = 8'h83; addr_data_2 = 8'd0; tick();
    checks++; if (dataout1 !== 16'h1083 || dataout2 !== 16'hBEEF) $display("[TB] FAIL mem_intact: got %h/%h expected 1083/beef", dataout1, dataout2); else passed++;
  endtask

  initial begin
    RST = 1'b1;
    write_en1 = 1'b0; addr_data_1 = '0; datain1 = '0;
    write_en2 = 1'b0; addr_data_2 = '0; datain2 = '0;
    host_valid = 1'b0; host_data = '0; host_start = 1'b0;
    core_done = 1'b0; dump_ready = 1'b0;
    test_reset();
    test_load_read();
    test_collision();
    test_read_during_write();
    test_dump();
    test_load_wrap();
    test_reset_mid_dump();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
